// File: rtl/lcd_read_strobe.sv
`default_nettype none
// ============================================================================
// Module      : lcd_read_strobe
// Description : Read-cycle sequencer for an HD44780-style character LCD.
//               Generates the RS/RW setup, the E strobe, the hold and the
//               enable-cycle gap. It samples the data bus at a fixed point
//               inside E-high. It can optionally repeat status reads until
//               the busy flag (DB7) clears, bounded by a timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   i_rd_req       in   single-cycle read request, taken only while o_idle=1
//   i_rd_rs        in   register select for a plain read (ignored when polling)
//   i_poll_busy    in   1 = repeat status reads until BF=0 or timeout
//   i_lcd_db_in    in   [7:0] data bus from the display
//   o_lcd_e        out  enable strobe
//   o_lcd_rw       out  1 while a read cycle is in progress
//   o_lcd_rs       out  register select to the display
//   o_lcd_db_oe    out  write-path bus drive enable, 0 while reading
//   o_rd_data      out  [7:0] last sampled byte
//   o_rd_valid     out  one-cycle pulse, transaction complete
//   o_busy_timeout out  one-cycle pulse with o_rd_valid when a poll timed out
//   o_idle         out  1 when a new request can be accepted
// ============================================================================
module lcd_read_strobe #(
  parameter int T_AS    = 3,      // address setup cycles before E rises
  parameter int T_PW    = 12,     // E-high cycles
  parameter int T_DDR   = 8,      // E-high cycle index at which DB is sampled
  parameter int T_H     = 2,      // hold cycles after E falls
  parameter int T_GAP   = 25,     // gap cycles before the next E rise
  parameter int TIMEOUT = 82000   // poll length limit in cycles
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rd_req,
  input  logic       i_rd_rs,
  input  logic       i_poll_busy,
  input  logic [7:0] i_lcd_db_in,
  output logic       o_lcd_e,
  output logic       o_lcd_rw,
  output logic       o_lcd_rs,
  output logic       o_lcd_db_oe,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic       o_busy_timeout,
  output logic       o_idle
);

  localparam int CW = 17;

  // Phase counter reload values: each phase lasts (reload + 1) cycles.
  localparam logic [CW-1:0] C_AS_M1   = CW'(T_AS - 1);
  localparam logic [CW-1:0] C_PW_M1   = CW'(T_PW - 1);
  localparam logic [CW-1:0] C_H_M1    = CW'(T_H - 1);
  localparam logic [CW-1:0] C_GAP_M1  = CW'(T_GAP - 1);
  // The counter counts down through E-high, so E-high cycle index k
  // corresponds to a counter value of T_PW-1-k.
  localparam logic [CW-1:0] C_DDR_CNT = CW'(T_PW - 1 - T_DDR);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_E_HIGH = 3'd2,
    S_HOLD   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_phase_cnt;
  logic [CW-1:0]   r_poll_cnt;
  logic            r_mode;
  logic            r_lcd_e;
  logic            r_lcd_rw;
  logic            r_lcd_rs;
  logic            r_lcd_db_oe;
  logic [7:0]      r_rd_data;
  logic            r_rd_valid;
  logic            r_busy_timeout;
  logic            r_idle;

  // Another status read is needed while polling, the display still reports
  // busy, and the poll has not yet run out of time.
  logic            w_repoll;
  assign w_repoll = r_mode && r_rd_data[7] && (r_poll_cnt < C_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_phase_cnt    <= '0;
      r_poll_cnt     <= '0;
      r_mode         <= 1'b0;
      r_lcd_e        <= 1'b0;
      r_lcd_rw       <= 1'b0;
      r_lcd_rs       <= 1'b0;
      r_lcd_db_oe    <= 1'b1;
      r_rd_data      <= 8'h00;
      r_rd_valid     <= 1'b0;
      r_busy_timeout <= 1'b0;
      r_idle         <= 1'b1;
    end else begin
      r_rd_valid     <= 1'b0;
      r_busy_timeout <= 1'b0;

      // Poll counter runs for the whole transaction and saturates.
      if (r_state != S_IDLE && r_poll_cnt < C_TIMEOUT) begin
        r_poll_cnt <= r_poll_cnt + 17'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_rd_req) begin
            r_state     <= S_SETUP;
            r_phase_cnt <= C_AS_M1;
            r_poll_cnt  <= '0;
            r_mode      <= i_poll_busy;
            // Busy polling always reads the status register.
            r_lcd_rs    <= i_poll_busy ? 1'b0 : i_rd_rs;
            r_lcd_rw    <= 1'b1;
            r_lcd_db_oe <= 1'b0;
            r_idle      <= 1'b0;
          end
        end

        S_SETUP: begin
          if (r_phase_cnt == '0) begin
            r_state     <= S_E_HIGH;
            r_lcd_e     <= 1'b1;
            r_phase_cnt <= C_PW_M1;
          end else begin
            r_phase_cnt <= r_phase_cnt - 17'd1;
          end
        end

        S_E_HIGH: begin
          if (r_phase_cnt == C_DDR_CNT) begin
            r_rd_data <= i_lcd_db_in;
          end
          if (r_phase_cnt == '0) begin
            r_state     <= S_HOLD;
            r_lcd_e     <= 1'b0;
            r_phase_cnt <= C_H_M1;
          end else begin
            r_phase_cnt <= r_phase_cnt - 17'd1;
          end
        end

        S_HOLD: begin
          if (r_phase_cnt == '0) begin
            r_state     <= S_GAP;
            r_phase_cnt <= C_GAP_M1;
          end else begin
            r_phase_cnt <= r_phase_cnt - 17'd1;
          end
        end

        S_GAP: begin
          if (r_phase_cnt == '0) begin
            if (w_repoll) begin
              r_state     <= S_SETUP;
              r_phase_cnt <= C_AS_M1;
              r_lcd_rs    <= 1'b0;
            end else begin
              r_state        <= S_IDLE;
              r_rd_valid     <= 1'b1;
              // Still busy at the exit decision means the poll timed out.
              r_busy_timeout <= r_mode && r_rd_data[7];
              r_lcd_rw       <= 1'b0;
              r_lcd_db_oe    <= 1'b1;
              r_idle         <= 1'b1;
            end
          end else begin
            r_phase_cnt <= r_phase_cnt - 17'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_lcd_e        = r_lcd_e;
  assign o_lcd_rw       = r_lcd_rw;
  assign o_lcd_rs       = r_lcd_rs;
  assign o_lcd_db_oe    = r_lcd_db_oe;
  assign o_rd_data      = r_rd_data;
  assign o_rd_valid     = r_rd_valid;
  assign o_busy_timeout = r_busy_timeout;
  assign o_idle         = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_lcd_read_strobe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_read_strobe
// Description : Scoreboard bench for lcd_read_strobe (TIMEOUT set to 200).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_read_strobe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rd_req = 1'b0;
  logic       i_rd_rs = 1'b0;
  logic       i_poll_busy = 1'b0;
  logic [7:0] i_lcd_db_in = 8'h00;
  logic       o_lcd_e, o_lcd_rw, o_lcd_rs, o_lcd_db_oe;
  logic [7:0] o_rd_data;
  logic       o_rd_valid, o_busy_timeout, o_idle;

  lcd_read_strobe #(.TIMEOUT(200)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rd_req       (i_rd_req),
    .i_rd_rs        (i_rd_rs),
    .i_poll_busy    (i_poll_busy),
    .i_lcd_db_in    (i_lcd_db_in),
    .o_lcd_e        (o_lcd_e),
    .o_lcd_rw       (o_lcd_rw),
    .o_lcd_rs       (o_lcd_rs),
    .o_lcd_db_oe    (o_lcd_db_oe),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_busy_timeout (o_busy_timeout),
    .o_idle         (o_idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int n_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       tmo;
    int         vcyc;
    int         pulses;
    logic       rs;
    int         first;
  } exp_t;

  exp_t sb[$];

  // ---------------------------------------------------------------- monitor
  int   m_pulses = 0;
  int   m_ehigh  = 0;
  int   m_first  = 0;
  logic m_rs_hi = 1'b0, m_rs_lo = 1'b0, m_rw_lo = 1'b0, m_prev_e = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pulses = 0; m_ehigh = 0; m_first = 0;
      m_rs_hi = 1'b0; m_rs_lo = 1'b0; m_rw_lo = 1'b0; m_prev_e = 1'b0;
    end else begin
      if (o_lcd_e) begin
        if (!m_prev_e) begin
          m_pulses++;
          if (m_pulses == 1) m_first = cyc;
        end
        m_ehigh++;
        if (o_lcd_rs) m_rs_hi = 1'b1; else m_rs_lo = 1'b1;
        if (!o_lcd_rw) m_rw_lo = 1'b1;
      end
      m_prev_e = o_lcd_e;
      if (o_rd_valid) begin
        exp_t x;
        n_valid++;
        if (sb.size() == 0) begin
          chk("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          x = sb.pop_front();
          chk("rd_data",        {24'd0, o_rd_data}, {24'd0, x.data});
          chk("busy_timeout",   {31'd0, o_busy_timeout}, {31'd0, x.tmo});
          chk("valid_cycle",    cyc, x.vcyc);
          chk("e_pulses",       m_pulses, x.pulses);
          chk("e_high_cycles",  m_ehigh, x.pulses * 12);
          chk("first_e_rise",   m_first, x.first);
          chk("rs_during_e",    {30'd0, m_rs_hi, m_rs_lo}, {30'd0, x.rs, ~x.rs});
          chk("rw_low_during_e", {31'd0, m_rw_lo}, 32'd0);
          chk("idle_with_valid", {31'd0, o_idle}, 32'd1);
          chk("oe_with_valid",  {31'd0, o_lcd_db_oe}, 32'd1);
          chk("rw_with_valid",  {31'd0, o_lcd_rw}, 32'd0);
        end
        m_pulses = 0; m_ehigh = 0; m_first = 0;
        m_rs_hi = 1'b0; m_rs_lo = 1'b0; m_rw_lo = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  // Called at a negedge; returns at the next negedge (cycle k+1).
  task automatic issue(input logic rs, input logic poll, input logic push,
                       input logic [7:0] data, input logic tmo,
                       input int npulse, input int lat, output int k);
    exp_t x;
    i_rd_rs = rs; i_poll_busy = poll; i_rd_req = 1'b1;
    k = cyc;
    if (push) begin
      x.data = data; x.tmo = tmo; x.vcyc = k + lat;
      x.pulses = npulse; x.rs = rs & ~poll; x.first = k + 4;
      sb.push_back(x);
    end
    @(negedge clk);
    i_rd_req = 1'b0;
    chk("idle_after_accept", {31'd0, o_idle}, 32'd0);
    chk("rw_after_accept",   {31'd0, o_lcd_rw}, 32'd1);
    chk("oe_after_accept",   {31'd0, o_lcd_db_oe}, 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(sb.size() == 0 && o_idle) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("wait_done_timeout", 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int falls;
    int v0;
    logic pe;

    repeat (3) @(negedge clk);
    chk("rst_lcd_e",   {31'd0, o_lcd_e}, 32'd0);
    chk("rst_lcd_rw",  {31'd0, o_lcd_rw}, 32'd0);
    chk("rst_lcd_rs",  {31'd0, o_lcd_rs}, 32'd0);
    chk("rst_db_oe",   {31'd0, o_lcd_db_oe}, 32'd1);
    chk("rst_rd_data", {24'd0, o_rd_data}, 32'd0);
    chk("rst_valid",   {31'd0, o_rd_valid}, 32'd0);
    chk("rst_timeout", {31'd0, o_busy_timeout}, 32'd0);
    chk("rst_idle",    {31'd0, o_idle}, 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain data read
    i_lcd_db_in = 8'hA5;
    issue(1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1, 43, k);
    wait_done(200);

    // Plain status read, bit7 set but no polling: one pulse only
    i_lcd_db_in = 8'h80;
    issue(1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1, 43, k);
    wait_done(200);

    // Poll that is not busy on the first read; rd_rs=1 must be ignored
    i_lcd_db_in = 8'h3C;
    issue(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1, 43, k);
    wait_done(200);

    // Busy poll: busy for three reads, then ready
    i_lcd_db_in = 8'h80;
    issue(1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 4, 169, k);
    falls = 0; pe = o_lcd_e;
    for (int n = 0; n < 400 && falls < 3; n++) begin
      @(negedge clk);
      if (pe && !o_lcd_e) falls++;
      pe = o_lcd_e;
    end
    chk("poll_e_falls", falls, 3);
    i_lcd_db_in = 8'h05;
    wait_done(400);

    // Poll timeout: bus stuck busy
    i_lcd_db_in = 8'hFF;
    issue(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 5, 211, k);
    wait_done(400);
    chk("idle_after_timeout", {31'd0, o_idle}, 32'd1);

    // Sample point: change at E-high cycle 9 is too late; extra request ignored
    i_lcd_db_in = 8'h11;
    issue(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1, 43, k);
    wait_cyc(k + 13);
    i_lcd_db_in = 8'h22;
    wait_cyc(k + 20);
    i_rd_req = 1'b1;
    @(negedge clk);
    i_rd_req = 1'b0;
    wait_done(200);

    // Sample point: change at E-high cycle 8 is captured
    i_lcd_db_in = 8'h33;
    issue(1'b1, 1'b0, 1'b1, 8'h44, 1'b0, 1, 43, k);
    wait_cyc(k + 12);
    i_lcd_db_in = 8'h44;
    wait_done(200);

    // Reset during E-high aborts the transaction
    i_lcd_db_in = 8'h77;
    issue(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 0, 0, k);
    wait_cyc(k + 8);
    chk("e_high_before_reset", {31'd0, o_lcd_e}, 32'd1);
    v0 = n_valid;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_e",    {31'd0, o_lcd_e}, 32'd0);
    chk("async_rst_oe",   {31'd0, o_lcd_db_oe}, 32'd1);
    chk("async_rst_rw",   {31'd0, o_lcd_rw}, 32'd0);
    chk("async_rst_idle", {31'd0, o_idle}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("no_valid_after_abort", n_valid, v0);

    // First request after reset completes normally
    i_lcd_db_in = 8'h5A;
    issue(1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1, 43, k);
    wait_done(200);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
